sync_down_counter: RTL and testbench



---
 rtl/sync_down_counter_pkg.sv | 38 +++
 rtl/sync_down_counter_if.sv | 47 ++++
 rtl/sync_down_counter_tff_cell.sv | 33 +++
 rtl/sync_down_counter.sv | 132 +++++++++++++
 tb/tb_sync_down_counter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/sync_down_counter_pkg.sv
// ----------------------------------------------------------------------------
// sync_down_counter_pkg
// Shared definitions for the loadable T-flip-flop down-counter:
//   - DEFAULT_WIDTH : default counter / load-value width
//   - MAX_WIDTH     : widest counter the mask helper supports
//   - state_t       : control FSM states (IDLE, RUN)
//   - lower_bits_zero() : helper that tells whether all bits below index i
//                         are zero, i.e. whether T cell i toggles on a
//                         decrement
// ----------------------------------------------------------------------------
package sync_down_counter_pkg;

    localparam int DEFAULT_WIDTH = 6;
    localparam int MAX_WIDTH     = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Returns 1 when v[i-1:0] is all zero (always 1 for i == 0). A down-count
    // flips bit i exactly when every lower bit is 0, so this is the per-bit
    // toggle qualifier of the decrement mask.
    function automatic logic lower_bits_zero(input logic [MAX_WIDTH-1:0] v,
                                             input int                   i);
        logic zero_s;
        zero_s = 1'b1;
        for (int j = 0; j < MAX_WIDTH; j++) begin
            if ((j < i) && v[j]) begin
                zero_s = 1'b0;
            end else begin
                zero_s = zero_s;
            end
        end
        return zero_s;
    endfunction

endpackage

// File: rtl/sync_down_counter_if.sv
// ----------------------------------------------------------------------------
// sync_down_counter_if
// Control/status bundle of the down-counter.
//   en          : count enable
//   load        : synchronous load strobe
//   load_value  : start value, also kept as the reload value
//   auto_reload : 1 = periodic, 0 = one-shot
//   count       : current count
//   busy        : high while the counter is running
//   tc          : one-cycle terminal-count pulse
// master = controller driving the counter, slave = the counter itself.
// ----------------------------------------------------------------------------
interface sync_down_counter_if
    import sync_down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;

    modport master (
        output en,
        output load,
        output load_value,
        output auto_reload,
        input  count,
        input  busy,
        input  tc
    );

    modport slave (
        input  en,
        input  load,
        input  load_value,
        input  auto_reload,
        output count,
        output busy,
        output tc
    );

endinterface

// File: rtl/sync_down_counter_tff_cell.sv
// ----------------------------------------------------------------------------
// tff_cell
// One bit of the down-counter: a T flip-flop with a synchronous parallel load.
//   clock  : rising-edge clock
//   clear  : asynchronous reset, active-low (q -> 0)
//   t      : toggle enable
//   d_load : value captured when ld is high
//   ld     : load strobe, has priority over t
//   q      : stored bit
// ----------------------------------------------------------------------------
module tff_cell (
    input  logic clock,
    input  logic clear,
    input  logic t,
    input  logic d_load,
    input  logic ld,
    output logic q
);

    // Bit storage: load beats toggle, otherwise hold.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            q <= 1'b0;
        end else if (ld) begin
            q <= d_load;
        end else if (t) begin
            q <= ~q;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/sync_down_counter.sv
// ----------------------------------------------------------------------------
// sync_down_counter
// Loadable synchronous down-counter used as a programmable interval timer.
// A load starts the count; enabled cycles decrement it; reaching zero and
// seeing one more enabled edge produces a one-cycle tc pulse and then either
// stops (one-shot) or reloads the stored start value (auto-reload).
//   clock : rising-edge clock
//   clear : asynchronous reset, active-low
//   bus   : sync_down_counter_if.slave (en, load, load_value, auto_reload,
//           count, busy, tc)
// Each count bit is a tff_cell; the decrement is a per-bit toggle mask
// (bit i toggles when all lower bits are zero), so there is no carry chain
// feeding the flops' clocks and no ripple clocking.
// ----------------------------------------------------------------------------
module sync_down_counter
    import sync_down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clock,
    input  logic                 clear,
    sync_down_counter_if.slave   bus
);

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [WIDTH-1:0]       reload_r;
    logic [WIDTH-1:0]       reload_nxt_s;
    logic                   tc_r;
    logic                   tc_nxt_s;

    logic                   ld_s;
    logic [WIDTH-1:0]       d_load_s;
    logic                   dec_s;
    logic [WIDTH-1:0]       t_s;
    logic [WIDTH-1:0]       q_s;
    logic [MAX_WIDTH-1:0]   count_ext_s;

    // Next-state, reload-register and cell-control decode; load has priority.
    always_comb begin
        state_nxt_s  = state_r;
        reload_nxt_s = reload_r;
        tc_nxt_s     = 1'b0;
        ld_s         = 1'b0;
        d_load_s     = bus.load_value;
        dec_s        = 1'b0;

        if (bus.load) begin
            ld_s         = 1'b1;
            d_load_s     = bus.load_value;
            reload_nxt_s = bus.load_value;
            if (bus.load_value != {WIDTH{1'b0}}) begin
                state_nxt_s = RUN;
            end else begin
                state_nxt_s = IDLE;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = IDLE;
                end
                RUN: begin
                    if (bus.en) begin
                        if (q_s != {WIDTH{1'b0}}) begin
                            dec_s = 1'b1;
                        end else begin
                            // Terminal edge: auto_reload is only looked at here.
                            tc_nxt_s = 1'b1;
                            if (bus.auto_reload) begin
                                ld_s     = 1'b1;
                                d_load_s = reload_r;
                                if (reload_r != {WIDTH{1'b0}}) begin
                                    state_nxt_s = RUN;
                                end else begin
                                    state_nxt_s = IDLE;
                                end
                            end else begin
                                // Count stays at 0: no toggle, no wrap.
                                state_nxt_s = IDLE;
                            end
                        end
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // Toggle mask: a qualified decrement flips bit i iff bits [i-1:0] are 0.
    always_comb begin
        count_ext_s              = {MAX_WIDTH{1'b0}};
        count_ext_s[WIDTH-1:0]   = q_s;
        t_s                      = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            t_s[i] = dec_s & lower_bits_zero(count_ext_s, i);
        end
    end

    // Control state, reload value and registered terminal-count pulse.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_r  <= IDLE;
            reload_r <= {WIDTH{1'b0}};
            tc_r     <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            reload_r <= reload_nxt_s;
            tc_r     <= tc_nxt_s;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        tff_cell u_cell (
            .clock  (clock),
            .clear  (clear),
            .t      (t_s[g]),
            .d_load (d_load_s[g]),
            .ld     (ld_s),
            .q      (q_s[g])
        );
    end

    // All outputs come straight from flops.
    assign bus.count = q_s;
    assign bus.busy  = (state_r == RUN);
    assign bus.tc    = tc_r;

endmodule

// File: tb/tb_sync_down_counter.sv
// ----------------------------------------------------------------------------
// tb_sync_down_counter
// Self-checking bench for sync_down_counter: directed scenarios followed by
// randomized traffic, all compared against an integer reference model that
// follows the timer's rules (load, decrement, terminal pulse, reload).
// ----------------------------------------------------------------------------
module tb_sync_down_counter;

    localparam int W = 6;

    logic clock;
    logic clear;

    sync_down_counter_if #(.WIDTH(W)) bus ();

    sync_down_counter #(.WIDTH(W)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    int tests_run;
    int tests_failed;

    // Reference model state.
    int m_count;
    int m_reload;
    bit m_run;
    bit m_tc;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input int observed, input int expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_count  = 0;
        m_reload = 0;
        m_run    = 1'b0;
        m_tc     = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, "_count"}, int'(bus.count), m_count);
        check_eq({tag, "_busy"},  int'(bus.busy),  int'(m_run));
        check_eq({tag, "_tc"},    int'(bus.tc),    int'(m_tc));
    endtask

    // One clock: drive inputs at the falling edge, advance model at the
    // rising edge, compare shortly after.
    task automatic step(input bit e, input bit l, input int v, input bit a, input string tag);
        @(negedge clock);
        bus.en          = e;
        bus.load        = l;
        bus.load_value  = v[W-1:0];
        bus.auto_reload = a;
        @(posedge clock);
        if (l) begin
            m_count  = v;
            m_reload = v;
            m_run    = (v != 0);
            m_tc     = 1'b0;
        end else if (m_run && e) begin
            if (m_count > 0) begin
                m_count = m_count - 1;
                m_tc    = 1'b0;
            end else begin
                m_tc = 1'b1;
                if (a) begin
                    m_count = m_reload;
                    m_run   = (m_reload != 0);
                end else begin
                    m_run = 1'b0;
                end
            end
        end else begin
            m_tc = 1'b0;
        end
        #1;
        check_model(tag);
    endtask

    // Drop clear between edges and verify outputs clear with no clock edge.
    task automatic clear_pulse(input string tag);
        @(negedge clock);
        #1 clear = 1'b0;
        #1;
        check_eq({tag, "_count"}, int'(bus.count), 0);
        check_eq({tag, "_busy"},  int'(bus.busy),  0);
        check_eq({tag, "_tc"},    int'(bus.tc),    0);
        model_reset();
        #1 clear = 1'b1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        model_reset();
        clear           = 1'b0;
        bus.en          = 1'b1;
        bus.load        = 1'b1;
        bus.load_value  = 6'h2A;
        bus.auto_reload = 1'b0;

        // Reset held while load toggles: everything stays 0.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            bus.load       = i[0];
            bus.load_value = i[0] ? 6'h2A : 6'h15;
            @(posedge clock);
            #1;
            check_eq("rst_count", int'(bus.count), 0);
            check_eq("rst_busy",  int'(bus.busy),  0);
            check_eq("rst_tc",    int'(bus.tc),    0);
        end
        @(negedge clock);
        bus.load = 1'b0;
        clear    = 1'b1;
        step(1'b1, 1'b0, 0, 1'b0, "post_rst");
        check_eq("post_rst_idle", int'(bus.count), 0);

        // One-shot from 5.
        step(1'b1, 1'b1, 5, 1'b0, "os_load");
        check_eq("os_load_val", int'(bus.count), 5);
        for (int i = 4; i >= 0; i--) begin
            step(1'b1, 1'b0, 0, 1'b0, "os_dec");
            check_eq("os_seq", int'(bus.count), i);
            check_eq("os_no_tc", int'(bus.tc), 0);
        end
        step(1'b1, 1'b0, 0, 1'b0, "os_term");
        check_eq("os_tc", int'(bus.tc), 1);
        check_eq("os_busy_low", int'(bus.busy), 0);
        step(1'b1, 1'b0, 0, 1'b0, "os_after");
        check_eq("os_tc_one_cycle", int'(bus.tc), 0);
        check_eq("os_stay0", int'(bus.count), 0);

        // Auto-reload from 3: period of 4 enabled cycles.
        step(1'b1, 1'b1, 3, 1'b1, "ar_load");
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b0, 0, 1'b1, "ar");
            check_eq("ar_seq", int'(bus.count), 3 - (i % 4));
            check_eq("ar_tc", int'(bus.tc), (i % 4 == 0) ? 1 : 0);
            check_eq("ar_busy", int'(bus.busy), 1);
        end

        // Enable gating.
        step(1'b0, 1'b1, 4, 1'b0, "eg_load");
        step(1'b1, 1'b0, 0, 1'b0, "eg1");
        check_eq("eg1_val", int'(bus.count), 3);
        step(1'b0, 1'b0, 0, 1'b0, "eg2");
        step(1'b0, 1'b0, 0, 1'b0, "eg3");
        check_eq("eg3_val", int'(bus.count), 3);
        step(1'b1, 1'b0, 0, 1'b0, "eg4");
        step(1'b1, 1'b0, 0, 1'b0, "eg5");
        check_eq("eg5_val", int'(bus.count), 1);
        step(1'b1, 1'b1, 0, 1'b0, "load0");
        check_eq("load0_busy", int'(bus.busy), 0);
        step(1'b1, 1'b0, 0, 1'b0, "load0_idle");
        check_eq("load0_no_tc", int'(bus.tc), 0);

        // Load colliding with the terminal edge, then full count-down from 63.
        step(1'b1, 1'b1, 1, 1'b0, "col_load");
        step(1'b1, 1'b0, 0, 1'b0, "col_zero");
        check_eq("col_at0", int'(bus.count), 0);
        step(1'b1, 1'b1, 63, 1'b0, "col_hit");
        check_eq("col_no_tc", int'(bus.tc), 0);
        check_eq("col_val", int'(bus.count), 63);
        for (int i = 0; i < 63; i++) begin
            step(1'b1, 1'b0, 0, 1'b0, "col_dec");
        end
        check_eq("col_reach0", int'(bus.count), 0);
        step(1'b1, 1'b0, 0, 1'b0, "col_term");
        check_eq("col_tc", int'(bus.tc), 1);
        step(1'b1, 1'b0, 0, 1'b0, "col_nowrap");
        check_eq("col_nowrap_val", int'(bus.count), 0);

        // Async clear mid-count.
        step(1'b1, 1'b1, 20, 1'b0, "ac_load");
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 0, 1'b0, "ac_dec");
        end
        check_eq("ac_at12", int'(bus.count), 12);
        clear_pulse("ac");
        step(1'b1, 1'b0, 0, 1'b0, "ac_idle");
        check_eq("ac_idle_val", int'(bus.count), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(99, 0));
            if (r == 0) begin
                clear_pulse("rnd_clr");
            end else begin
                step(($urandom_range(9, 0) < 7),
                     ($urandom_range(29, 0) == 0),
                     (($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 0))
                                                  : int'($urandom_range(63, 0))),
                     $urandom_range(1, 0) == 1,
                     "rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
